// File: rtl/divisor_secuencial_if.sv
// Handshake and operand/result bundle of the sequential divider.
// The master drives inicio and the operands; the slave (divider) returns the result and status.
interface divisor_secuencial_if #(
  parameter int N = 4
);
  logic         inicio;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] cociente;
  logic [N-1:0] resto;
  logic         listo;
  logic         fin;
  logic         div_cero;

  modport master (
    output inicio, dividendo, divisor,
    input  cociente, resto, listo, fin, div_cero
  );

  modport slave (
    input  inicio, dividendo, divisor,
    output cociente, resto, listo, fin, div_cero
  );
endinterface

// File: rtl/divisor_secuencial.sv
// Unsigned restoring divider: one quotient bit per clock, N+2 cycles per operation.
// inicio is only accepted in REPOSO (listo=1); requests while busy are dropped without side effects.
module divisor_secuencial #(
  parameter int N = 4
) (
  input logic             clk,
  input logic             reset,
  divisor_secuencial_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULA = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          div_cero_q, div_cero_d;

  logic          acepta;
  logic          divisor_nulo;
  logic          ultimo;
  logic [2*N:0]  aq_sh;
  logic [N:0]    a_sh;
  logic [N-1:0]  q_sh;
  logic [N:0]    t;
  logic          listo;
  logic          fin;

  assign acepta       = (estado_q == REPOSO) && bus.inicio;
  assign divisor_nulo = (bus.divisor == '0);
  assign ultimo       = (cnt_q == CW'(1));

  // One restoring step: shift {A,Q} left and trial-subtract the divisor.
  assign aq_sh = {a_q, q_q} << 1;
  assign a_sh  = aq_sh[2*N:N];
  assign q_sh  = aq_sh[N-1:0];
  assign t     = a_sh - {1'b0, m_q};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= REPOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO: begin
        if (acepta) begin
          estado_d = divisor_nulo ? FIN : CALCULA;
        end
      end
      CALCULA: begin
        if (ultimo) begin
          estado_d = FIN;
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Output logic
  always_comb begin
    listo = 1'b0;
    fin   = 1'b0;
    case (estado_q)
      REPOSO:  listo = 1'b1;
      FIN:     fin   = 1'b1;
      default: begin
        listo = 1'b0;
        fin   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      div_cero_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      q_q        <= q_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      div_cero_q <= div_cero_d;
    end
  end

  always_comb begin
    a_d        = a_q;
    q_d        = q_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    div_cero_d = div_cero_q;
    case (estado_q)
      REPOSO: begin
        if (acepta) begin
          m_d = bus.divisor;
          if (divisor_nulo) begin
            // Division by zero: all-ones quotient, dividend left as remainder.
            a_d        = {1'b0, bus.dividendo};
            q_d        = '1;
            div_cero_d = 1'b1;
          end else begin
            a_d        = '0;
            q_d        = bus.dividendo;
            cnt_d      = CW'(N);
            div_cero_d = 1'b0;
          end
        end
      end
      CALCULA: begin
        if (!t[N]) begin
          a_d = t;
          q_d = q_sh | N'(1);
        end else begin
          a_d = a_sh;
          q_d = q_sh;
        end
        cnt_d = cnt_q - CW'(1);
      end
      default: begin
        a_d = a_q;
      end
    endcase
  end

  assign bus.cociente = q_q;
  assign bus.resto    = a_q[N-1:0];
  assign bus.listo    = listo;
  assign bus.fin      = fin;
  assign bus.div_cero = div_cero_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Scoreboard bench for divisor_secuencial: the driver queues expected results at each accept,
// a negedge monitor pops and checks them on every fin pulse (values, timing, invariant).
module tb_divisor_secuencial;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  divisor_secuencial_if #(.N(N)) bus ();

  divisor_secuencial #(.N(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic fin_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: every fin pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.fin === 1'b1) begin
          check("fin_single_cycle", 32'(fin_prev), 32'd0);
          if (sb.size() == 0) begin
            fail_now("unexpected_fin");
          end else begin
            e = sb.pop_front();
            check("cociente", 32'(bus.cociente), 32'(e.q));
            check("resto", 32'(bus.resto), 32'(e.r));
            check("div_cero", 32'(bus.div_cero), 32'(e.dz));
            check("fin_cycle", 32'(cyc), 32'(e.cyc));
            check("listo_at_fin", 32'(bus.listo), 32'd0);
            if (!e.dz) begin
              check("invariant", 32'(bus.cociente) * 32'(e.b) + 32'(bus.resto), 32'(e.a));
              check("resto_lt_divisor", 32'(bus.resto < e.b), 32'd1);
            end
          end
        end
        fin_prev = bus.fin;
      end else begin
        fin_prev = 1'b0;
      end
    end
  end

  task automatic wait_listo();
    int g;
    g = 0;
    @(negedge clk);
    while (bus.listo !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail_now("listo_timeout");
  endtask

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] q, input logic [N-1:0] r,
                          input logic dz, input bit push);
    exp_t e;
    wait_listo();
    bus.dividendo = a;
    bus.divisor   = b;
    bus.inicio    = 1'b1;
    @(posedge clk);
    #1;
    bus.inicio    = 1'b0;
    bus.dividendo = N'($urandom);
    bus.divisor   = N'($urandom);
    if (push) begin
      e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
      e.cyc = cyc + (dz ? 0 : N);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) fail_now("result_timeout");
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   g;
    int   acc;
    reset         = 1'b0;
    bus.inicio    = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;
    #12;
    check("rst_listo", 32'(bus.listo), 32'd1);
    check("rst_fin", 32'(bus.fin), 32'd0);
    check("rst_cociente", 32'(bus.cociente), 32'd0);
    check("rst_resto", 32'(bus.resto), 32'd0);
    check("rst_div_cero", 32'(bus.div_cero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic operation and boundary operands
    start_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
    wait_idle();
    check("listo_after_op", 32'(bus.listo), 32'd1);
    start_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b1);
    start_op(4'd7, 4'd9, 4'd0, 4'd7, 1'b0, 1'b1);
    start_op(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1);
    start_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b1);
    wait_idle();

    // Divide by zero, then a normal op clears div_cero
    start_op(4'd11, 4'd0, 4'd15, 4'd11, 1'b1, 1'b1);
    wait_idle();
    check("div_cero_sticky", 32'(bus.div_cero), 32'd1);
    start_op(4'd12, 4'd4, 4'd3, 4'd0, 1'b0, 1'b1);
    wait_idle();

    // Requests while busy are ignored
    start_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    bus.inicio = 1'b1; bus.dividendo = 4'd9; bus.divisor = 4'd2;
    @(negedge clk);
    bus.inicio = 1'b0;
    g = 0;
    while (bus.fin !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) fail_now("busy_fin_timeout");
    bus.inicio = 1'b1; bus.dividendo = 4'd9; bus.divisor = 4'd2;
    @(posedge clk);
    #1;
    bus.inicio = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("busy_listo", 32'(bus.listo), 32'd1);
    check("busy_cociente_held", 32'(bus.cociente), 32'd4);
    check("busy_resto_held", 32'(bus.resto), 32'd2);

    // inicio held high: re-accepted on the first listo edge
    wait_listo();
    bus.dividendo = 4'd10; bus.divisor = 4'd3; bus.inicio = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    e.a = 4'd10; e.b = 4'd3; e.q = 4'd3; e.r = 4'd1; e.dz = 1'b0;
    e.cyc = acc + N;
    sb.push_back(e);
    e.cyc = acc + 2 * N + 2;
    sb.push_back(e);
    repeat (N + 2) @(posedge clk);
    #1;
    bus.inicio = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation
    start_op(4'd13, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_listo", 32'(bus.listo), 32'd1);
    check("mid_rst_fin", 32'(bus.fin), 32'd0);
    check("mid_rst_cociente", 32'(bus.cociente), 32'd0);
    check("mid_rst_resto", 32'(bus.resto), 32'd0);
    check("mid_rst_div_cero", 32'(bus.div_cero), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (N + 3) @(negedge clk);
    start_op(4'd6, 4'd4, 4'd1, 4'd2, 1'b0, 1'b1);
    wait_idle();

    // Exhaustive sweep against the arithmetic definition
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) start_op(4'(a), 4'(b), 4'd15, 4'(a), 1'b1, 1'b1);
        else        start_op(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 1'b1);
      end
    end
    wait_idle();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
